sargantana_icache_refill: RTL
=============================

Name: sargantana_icache_refill

Overview:
- Miss/refill stage directly upstream of the icache tag/data checker.
- On a lookup miss, issues one line request to L2 and collects the response beats into a full cache line.
- Presents the line as ifill_data_o (the checker's ifill_data_i) with tag, set index and victim way, so the line can be written into the tag/data arrays and forwarded to fetch.
- Handles flush/kill while a request is in flight by draining the outstanding beats without filling.

Parameters:
- PADDR_WIDTH, 40, physical address width.
- BEAT_WIDTH, 128, L2 response data width per beat.
- LINE_WIDTH, WAY_WIDHT (512), cache line width. Must be a multiple of BEAT_WIDTH.
- N_BEATS, LINE_WIDTH/BEAT_WIDTH (4), beats per line. Derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- miss_i  in  1  lookup miss; sampled only in IDLE
- miss_paddr_i  in  PADDR_WIDTH  physical address of the missing fetch
- way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the indexed set; sampled with miss_i
- flush_i  in  1  kill/flush; aborts the current refill
- req_valid_o  out  1  L2 line request valid
- req_ready_i  in  1  L2 accepts the request
- req_addr_o  out  PADDR_WIDTH  line-aligned request address; low log2(LINE_WIDTH/8) bits are 0
- resp_valid_i  in  1  L2 beat valid; no backpressure
- resp_data_i  in  BEAT_WIDTH  beat data
- resp_error_i  in  1  beat carries a bus error
- ifill_data_o  out  LINE_WIDTH  assembled line
- fill_valid_o  out  1  one-cycle pulse: write the line into the arrays
- fill_way_o  out  ICACHE_N_WAY  one-hot victim way
- fill_tag_o  out  ICACHE_TAG_WIDTH  tag of the filled line
- fill_idx_o  out  ICACHE_IDX_WIDTH  set index of the filled line
- fill_error_o  out  1  one-cycle pulse: refill completed with an error; no fill issued
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE; every output 0; beat counter 0; round-robin pointer 0; error flag 0.
- Ports only; no state is shared with the checker.
- FSM states: IDLE, REQ, COLLECT, DRAIN, DONE.
- IDLE:
  - miss_i=1 and flush_i=0: latch the line address, tag, index and victim; go to REQ.
  - miss_i together with flush_i: ignored.
- Victim choice, fixed at miss acceptance:
  - Lowest-index invalid way in way_valid_bits_i.
  - If all ways are valid, one-hot of the round-robin pointer.
  - The pointer advances, mod ICACHE_N_WAY, only on a fill that used it.
- REQ:
  - req_valid_o=1 and req_addr_o stable until the handshake (req_valid_o & req_ready_i).
  - Handshake: go to COLLECT; clear the beat counter and error flag.
  - flush_i without handshake: go to IDLE; no request is outstanding.
  - flush_i in the handshake cycle: go to DRAIN.
- COLLECT:
  - Each resp_valid_i writes resp_data_i into ifill_data_o[cnt*BEAT_WIDTH +: BEAT_WIDTH], with beat 0 at the LSBs.
  - Each beat ORs resp_error_i into the error flag and increments the counter.
  - On the beat with cnt==N_BEATS-1, go to DONE.
  - flush_i in any COLLECT cycle, including the last-beat cycle: go to DRAIN. That cycle's beat is still counted; no fill is issued.
- DRAIN:
  - Counts the remaining beats without writing data.
  - When the beat with cnt==N_BEATS-1 is received, go to IDLE. If the flush arrived on the last beat, go to IDLE immediately.
  - No fill_* pulse is produced.
- DONE (one cycle):
  - Error flag clear: fill_valid_o=1.
  - Error flag set: fill_error_o=1 and fill_valid_o=0.
  - Go to IDLE. flush_i in DONE does not suppress the pulse.
- Latency:
  - miss at cycle 0 gives req_valid_o at cycle 1.
  - Last beat accepted at cycle t gives fill_valid_o at cycle t+1.
- ifill_data_o, fill_tag_o, fill_idx_o and fill_way_o hold their values until the next miss is accepted.
- resp_valid_i in IDLE or REQ is ignored. L2 protocol guarantees no stray beats.
- Reset mid-operation: immediate return to reset values. The bench must not deliver beats belonging to the aborted request.

Decomposition:
- Add to sargantana_icache_pkg:
  - ICACHE_IDX_WIDTH and ICACHE_LINE_OFFSET.
  - refill_state_t (enum of the FSM states).
  - icache_l2_req_t / icache_l2_resp_t structs, optional bundling of the L2 ports.
- Existing package constants reused: ICACHE_TAG_WIDTH, ICACHE_N_WAY, WAY_WIDHT.
- One sub-module, sargantana_icache_victim_sel: first-invalid priority pick plus round-robin pointer.

Test Plan:
- miss_paddr_i=0x80001234, set invalid, req_ready_i=1, 4 beats A0..A3 → req_addr_o=0x80001200; ifill_data_o={A3,A2,A1,A0}; fill_valid_o one cycle after A3; fill_way_o=0001.
- way_valid_bits_i=1011 → fill_way_o=0100. Then three misses with 1111 → fill_way_o=0001, 0010, 0100 (pointer advances).
- req_ready_i held low 5 cycles → req_valid_o stays high, req_addr_o stable; fill occurs 1 cycle after the last beat.
- flush_i after beat 1 → DRAIN, beats 2–3 absorbed, no fill_valid_o; busy_o falls after beat 3; next miss gets a fresh request.
- resp_error_i on beat 2 → fill_error_o pulse, fill_valid_o=0, round-robin pointer unchanged.
- flush_i in REQ with req_ready_i=0 → IDLE next cycle, no beats expected; rst_i in COLLECT → all outputs 0 next cycle.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared icache constants and types.
// Holds the geometry of the instruction cache (ways, line size, set and tag
// widths) plus the refill FSM state encoding and optional L2 bundle structs.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_PADDR_WIDTH = 40;
  localparam int unsigned ICACHE_N_WAY       = 4;
  localparam int unsigned WAY_WIDHT          = 512;
  localparam int unsigned L2_BEAT_WIDTH      = 128;

  // Byte offset inside a line and set index width (64 sets of 64-byte lines).
  localparam int unsigned ICACHE_LINE_OFFSET = $clog2(WAY_WIDHT / 8);
  localparam int unsigned ICACHE_IDX_WIDTH   = 6;
  localparam int unsigned ICACHE_TAG_WIDTH   =
    ICACHE_PADDR_WIDTH - ICACHE_IDX_WIDTH - ICACHE_LINE_OFFSET;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    COLLECT = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } refill_state_t;

  typedef struct packed {
    logic                          valid;
    logic [ICACHE_PADDR_WIDTH-1:0] addr;
  } icache_l2_req_t;

  typedef struct packed {
    logic                     valid;
    logic [L2_BEAT_WIDTH-1:0] data;
    logic                     error;
  } icache_l2_resp_t;

  // One-hot of the lowest clear bit; zero when every bit is set.
  function automatic logic [ICACHE_N_WAY-1:0] first_invalid_onehot(
    input logic [ICACHE_N_WAY-1:0] valid
  );
    return ~valid & (valid + 1'b1);
  endfunction

endpackage

// File: rtl/sargantana_icache_refill_if.sv
// L2 line request / beat response channel between the icache refill stage
// and the L2.
// Signal names are from the refill side: *_o driven by refill, *_i by L2.
//   req_valid_o/req_ready_i/req_addr_o    : line request handshake
//   resp_valid_i/resp_data_i/resp_error_i : response beats, no backpressure
interface sargantana_icache_refill_if
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = ICACHE_PADDR_WIDTH,
  parameter int unsigned BEAT_WIDTH  = L2_BEAT_WIDTH
);

  logic                   req_valid_o;
  logic                   req_ready_i;
  logic [PADDR_WIDTH-1:0] req_addr_o;
  logic                   resp_valid_i;
  logic [BEAT_WIDTH-1:0]  resp_data_i;
  logic                   resp_error_i;

  modport master (
    output req_valid_o,
    output req_addr_o,
    input  req_ready_i,
    input  resp_valid_i,
    input  resp_data_i,
    input  resp_error_i
  );

  modport slave (
    input  req_valid_o,
    input  req_addr_o,
    output req_ready_i,
    output resp_valid_i,
    output resp_data_i,
    output resp_error_i
  );

endinterface

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way selection for icache refills.
// Picks the lowest-index invalid way; when the set is full it falls back to a
// round-robin pointer, which advances only when a fill actually consumed it.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   way_valid_bits_i : valid bits of the indexed set
//   advance_i        : a fill that used the round-robin choice completed
//   victim_o         : one-hot victim way
//   use_rr_o         : victim_o came from the round-robin pointer
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ICACHE_N_WAY-1:0] way_valid_bits_i,
  input  logic                    advance_i,
  output logic [ICACHE_N_WAY-1:0] victim_o,
  output logic                    use_rr_o
);

  localparam int unsigned PTR_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ICACHE_N_WAY - 1);
  localparam logic [ICACHE_N_WAY-1:0] ONE = ICACHE_N_WAY'(1);

  logic [PTR_W-1:0] rr_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (advance_i) begin
      rr_ptr <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + 1'b1;
    end
  end

  always_comb begin
    use_rr_o = &way_valid_bits_i;
    victim_o = use_rr_o ? (ONE << rr_ptr) : first_invalid_onehot(way_valid_bits_i);
  end

endmodule

// File: rtl/sargantana_icache_refill.sv
// Icache miss/refill stage.
// On an accepted miss it issues one line request to L2, assembles the beats
// into a full line and presents it with tag, set index and victim way for the
// tag/data checker to write. A flush while a request is outstanding drains
// the remaining beats without filling.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   miss_i, miss_paddr_i, way_valid_bits_i : lookup miss and its context
//   flush_i             : kill the current refill
//   l2                  : L2 request/response channel (master side)
//   ifill_data_o        : assembled line, beat 0 at the LSBs
//   fill_valid_o        : one-cycle write strobe for the arrays
//   fill_way_o/fill_tag_o/fill_idx_o : where the line goes
//   fill_error_o        : one-cycle pulse, line had a bus error, no fill
//   busy_o              : refill in progress
module sargantana_icache_refill
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = ICACHE_PADDR_WIDTH,
  parameter int unsigned BEAT_WIDTH  = L2_BEAT_WIDTH,
  parameter int unsigned LINE_WIDTH  = WAY_WIDHT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        miss_i,
  input  logic [PADDR_WIDTH-1:0]      miss_paddr_i,
  input  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i,
  input  logic                        flush_i,
  sargantana_icache_refill_if.master  l2,
  output logic [LINE_WIDTH-1:0]       ifill_data_o,
  output logic                        fill_valid_o,
  output logic [ICACHE_N_WAY-1:0]     fill_way_o,
  output logic [ICACHE_TAG_WIDTH-1:0] fill_tag_o,
  output logic [ICACHE_IDX_WIDTH-1:0] fill_idx_o,
  output logic                        fill_error_o,
  output logic                        busy_o
);

  localparam int unsigned N_BEATS  = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  refill_state_t state, state_d;

  logic [CNT_W-1:0]        cnt;
  logic                    err;
  logic                    use_rr_q;
  logic [PADDR_WIDTH-1:0]  req_addr_q;
  logic [ICACHE_N_WAY-1:0] victim;
  logic                    victim_use_rr;
  logic                    advance_rr;
  logic                    accept_miss;

  // Offset bits only matter for the critical-word position, which this
  // stage does not use: the request is always for the whole line.
  logic unused_offset;
  assign unused_offset = ^miss_paddr_i[OFFSET_W-1:0];

  assign accept_miss = (state == IDLE) && miss_i && !flush_i;

  sargantana_icache_victim_sel u_victim_sel (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .way_valid_bits_i (way_valid_bits_i),
    .advance_i        (advance_rr),
    .victim_o         (victim),
    .use_rr_o         (victim_use_rr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d        = state;
    advance_rr     = 1'b0;
    fill_valid_o   = 1'b0;
    fill_error_o   = 1'b0;
    l2.req_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept_miss) state_d = REQ;
      end
      REQ: begin
        l2.req_valid_o = 1'b1;
        // Once the handshake happens the beats are owed to us, so a flush
        // in that same cycle must still drain them.
        if (l2.req_ready_i) state_d = flush_i ? DRAIN : COLLECT;
        else if (flush_i)   state_d = IDLE;
      end
      COLLECT: begin
        if (l2.resp_valid_i && (cnt == LAST_BEAT)) state_d = flush_i ? IDLE : DONE;
        else if (flush_i)                          state_d = DRAIN;
      end
      DRAIN: begin
        if (l2.resp_valid_i && (cnt == LAST_BEAT)) state_d = IDLE;
      end
      DONE: begin
        fill_valid_o = !err;
        fill_error_o = err;
        advance_rr   = !err && use_rr_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt          <= '0;
      err          <= 1'b0;
      use_rr_q     <= 1'b0;
      req_addr_q   <= '0;
      ifill_data_o <= '0;
      fill_way_o   <= '0;
      fill_tag_o   <= '0;
      fill_idx_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_miss) begin
            req_addr_q <= {miss_paddr_i[PADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            fill_tag_o <= miss_paddr_i[OFFSET_W+ICACHE_IDX_WIDTH +: ICACHE_TAG_WIDTH];
            fill_idx_o <= miss_paddr_i[OFFSET_W +: ICACHE_IDX_WIDTH];
            fill_way_o <= victim;
            use_rr_q   <= victim_use_rr;
          end
        end
        REQ: begin
          if (l2.req_ready_i) begin
            cnt <= '0;
            err <= 1'b0;
          end
        end
        COLLECT: begin
          if (l2.resp_valid_i) begin
            ifill_data_o[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= l2.resp_data_i;
            err <= err | l2.resp_error_i;
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (l2.resp_valid_i) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign l2.req_addr_o = req_addr_q;
  assign busy_o        = (state != IDLE);

endmodule
